alu_result_bcd: RTL and testbench

Downstream stage of the 4-bit ALU. It takes the ALU's 8-bit result F and converts it from unsigned binary to three BCD digits using iterative shift-add-3 (double dabble), one bit per clock. It registers the digits and the matching 7-segment patterns that drive the board HEX displays. A valid/ready handshake lets the operand/command logic present a new result only when the converter is free.

---
 rtl/alu_result_bcd.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_result_bcd.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_bcd
//  Purpose  : Converts the 8-bit unsigned ALU result into BCD digits with an
//             iterative shift-add-3 (double dabble) engine, one bit per clock,
//             and registers the digits plus 7-segment patterns for the board
//             HEX displays.
//  Ports    : clk, rst         - clock (rising edge), synchronous active-high
//                                reset
//             in_valid/in_ready- accept handshake; a result is taken only
//                                while the converter is idle
//             in_data          - unsigned binary value to convert
//             bcd              - registered BCD digits, [3:0] = ones
//             hex0..hex2       - registered 7-seg patterns (gfedcba, bit0 = a)
//                                for ones, tens, hundreds
//             busy             - conversion in progress
//             done             - one-cycle pulse when bcd/hex update
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_bcd #(
    parameter int IN_W           = 8,
    parameter int DIGITS         = 3,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LZ       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            hex0,
    output logic [6:0]            hex1,
    output logic [6:0]            hex2,
    output logic                  busy,
    output logic                  done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    // The three display digits are always extracted, even for DIGITS < 3.
    localparam int PAD_D = (DIGITS > 3) ? DIGITS : 3;
    localparam int PAD_W = 4 * PAD_D;
    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(IN_W);

    // ------------------------------------------------------------------------
    // 7-segment encoder; codes above 9 cannot come out of the converter and
    // are shown blank.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg_encode(input logic [3:0] d, input logic blank);
        logic [6:0] s;
        s = 7'h00;
        if (!blank) begin
            case (d)
                4'd0:    s = 7'h3F;
                4'd1:    s = 7'h06;
                4'd2:    s = 7'h5B;
                4'd3:    s = 7'h4F;
                4'd4:    s = 7'h66;
                4'd5:    s = 7'h6D;
                4'd6:    s = 7'h7D;
                4'd7:    s = 7'h07;
                4'd8:    s = 7'h7F;
                4'd9:    s = 7'h6F;
                default: s = 7'h00;
            endcase
        end
        if (SEG_ACTIVE_LOW != 0) begin
            s = ~s;
        end
        return s;
    endfunction

    localparam logic [6:0] C_HEX_ZERO = seg_encode(4'd0, 1'b0);
    localparam logic [6:0] C_HEX_LZ   = seg_encode(4'd0, BLANK_LZ != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [IN_W-1:0]        r_bin;
    logic [BCD_W-1:0]       r_work;
    logic [CNT_W-1:0]       r_cnt;
    logic [BCD_W-1:0]       r_bcd;
    logic [6:0]             r_hex0;
    logic [6:0]             r_hex1;
    logic [6:0]             r_hex2;
    logic                   r_done;

    logic                   w_in_ready;
    logic                   w_busy;
    logic                   w_accept;
    logic                   w_shift_en;
    logic                   w_load;

    logic [BCD_W-1:0]       w_adj;
    logic [BCD_W-1:0]       w_work_next;
    logic [PAD_W-1:0]       w_pad;
    logic [3:0]             w_d0;
    logic [3:0]             w_d1;
    logic [3:0]             w_d2;
    logic                   w_blank1;
    logic                   w_blank2;
    logic [6:0]             w_hex0;
    logic [6:0]             w_hex1;
    logic [6:0]             w_hex2;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_accept     = 1'b0;
        w_shift_en   = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_busy     = 1'b1;
                w_shift_en = 1'b1;
                // The shift taking the count from 1 to 0 is the last one.
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Double-dabble step: correct every digit >= 5 by +3, then shift the
    // binary MSB into BCD bit 0. The top bit of the corrected vector falls
    // off; it is always 0 when 10^DIGITS covers the input range.
    // ------------------------------------------------------------------------
    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_work[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
            end
        end
        w_work_next = BCD_W'({w_adj, r_bin[IN_W-1]});
    end

    // ------------------------------------------------------------------------
    // Display encode from the finished working register.
    // ------------------------------------------------------------------------
    assign w_pad    = PAD_W'(r_work);
    assign w_d0     = w_pad[3:0];
    assign w_d1     = w_pad[7:4];
    assign w_d2     = w_pad[11:8];
    assign w_blank2 = (BLANK_LZ != 0) && (w_d2 == 4'd0);
    assign w_blank1 = w_blank2 && (w_d1 == 4'd0);
    assign w_hex0   = seg_encode(w_d0, 1'b0);
    assign w_hex1   = seg_encode(w_d1, w_blank1);
    assign w_hex2   = seg_encode(w_d2, w_blank2);

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_work <= '0;
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_hex0 <= C_HEX_ZERO;
            r_hex1 <= C_HEX_LZ;
            r_hex2 <= C_HEX_LZ;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_bin  <= in_data;
                r_work <= '0;
                r_cnt  <= C_CNT_INIT;
            end
            if (w_shift_en) begin
                r_bin  <= {r_bin[IN_W-2:0], 1'b0};
                r_work <= w_work_next;
                r_cnt  <= r_cnt - CNT_W'(1);
            end
            // Outputs only move here, so the display never shows partial work.
            if (w_load) begin
                r_bcd  <= r_work;
                r_hex0 <= w_hex0;
                r_hex1 <= w_hex1;
                r_hex2 <= w_hex2;
                r_done <= 1'b1;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign busy     = w_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign hex0     = r_hex0;
    assign hex1     = r_hex1;
    assign hex2     = r_hex2;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_bcd
//  Purpose  : Directed self-checking bench for alu_result_bcd (default
//             parameters: 8-bit input, 3 digits, active-low segments,
//             leading-zero blanking).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_bcd;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [11:0] bcd;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;
    logic        busy;
    logic        done;

    int pass_cnt;
    int total_cnt;

    // Active-low gfedcba patterns for digits 0..9; blank is 7F.
    logic [6:0] seg_lo [10];

    alu_result_bcd #(
        .IN_W           (8),
        .DIGITS         (3),
        .SEG_ACTIVE_LOW (1),
        .BLANK_LZ       (1)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .bcd      (bcd),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] model_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic logic [20:0] model_hex(input int v);
        int h, t, o;
        logic [6:0] e2, e1, e0;
        h  = v / 100;
        t  = (v / 10) % 10;
        o  = v % 10;
        e2 = (h == 0) ? 7'h7F : seg_lo[h];
        e1 = (h == 0 && t == 0) ? 7'h7F : seg_lo[t];
        e0 = seg_lo[o];
        return {e2, e1, e0};
    endfunction

    // Presents v, waits for acceptance then for done. lat counts edges from
    // the accept edge to the edge after which done is seen; busy_n counts
    // sampled busy cycles; hold_chg counts cycles where outputs moved before
    // done; to flags an expired bound.
    task automatic convert(input logic [7:0] v, output int lat, output int busy_n,
                           output int hold_chg, output bit to);
        logic [11:0] p_bcd;
        logic [20:0] p_hex;
        int          guard;
        lat      = 0;
        busy_n   = 0;
        hold_chg = 0;
        to       = 1'b0;
        p_bcd    = bcd;
        p_hex    = {hex2, hex1, hex0};
        in_data  = v;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 40) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        if (busy) busy_n++;
        while (!done && lat < 40) begin
            if (bcd !== p_bcd || {hex2, hex1, hex0} !== p_hex) hold_chg++;
            tick();
            lat++;
            if (busy) busy_n++;
        end
        if (!done) to = 1'b1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({in_ready, busy, done} !== 3'b100) $display("FAIL reset_ctrl: got %b expected 100", {in_ready, busy, done});
        else pass_cnt++;
        total_cnt++;
        if ({bcd, hex2, hex1, hex0} !== {12'h000, 7'h7F, 7'h7F, 7'h40})
            $display("FAIL reset_out: got bcd=%h hex=%h/%h/%h expected 000 7f/7f/40", bcd, hex2, hex1, hex0);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        int lat, bn, hc; bit to;
        convert(8'd0, lat, bn, hc, to);
        total_cnt++;
        if (to || lat != 9) $display("FAIL zero_latency: got %0d expected 9 (timeout=%0b)", lat, to);
        else pass_cnt++;
        total_cnt++;
        if ({bcd, hex2, hex1, hex0} !== {12'h000, 7'h7F, 7'h7F, 7'h40})
            $display("FAIL zero_out: got bcd=%h hex=%h/%h/%h expected 000 7f/7f/40", bcd, hex2, hex1, hex0);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL zero_ready_with_done: got %b expected 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_max();
        int lat, bn, hc, dn; bit to;
        convert(8'hFF, lat, bn, hc, to);
        total_cnt++;
        if ({bcd, hex2, hex1, hex0} !== {12'h255, 7'h24, 7'h12, 7'h12})
            $display("FAIL max_out: got bcd=%h hex=%h/%h/%h expected 255 24/12/12", bcd, hex2, hex1, hex0);
        else pass_cnt++;
        total_cnt++;
        if (to || bn != 8) $display("FAIL max_busy_cycles: got %0d expected 8", bn);
        else pass_cnt++;
        dn = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) dn++;
        end
        total_cnt++;
        if (dn != 1) $display("FAIL max_done_width: got %0d expected 1", dn);
        else pass_cnt++;
    endtask

    task automatic test_blanking();
        int lat, bn, hc; bit to;
        convert(8'd100, lat, bn, hc, to);
        total_cnt++;
        if (to || {bcd, hex2, hex1, hex0} !== {12'h100, 7'h79, 7'h40, 7'h40})
            $display("FAIL blank_100: got bcd=%h hex=%h/%h/%h expected 100 79/40/40", bcd, hex2, hex1, hex0);
        else pass_cnt++;
        convert(8'd7, lat, bn, hc, to);
        total_cnt++;
        if (to || {bcd, hex2, hex1, hex0} !== {12'h007, 7'h7F, 7'h7F, 7'h78})
            $display("FAIL blank_7: got bcd=%h hex=%h/%h/%h expected 007 7f/7f/78", bcd, hex2, hex1, hex0);
        else pass_cnt++;
        convert(8'd42, lat, bn, hc, to);
        total_cnt++;
        if (to || {bcd, hex2, hex1, hex0} !== {12'h042, 7'h7F, 7'h19, 7'h24})
            $display("FAIL blank_42: got bcd=%h hex=%h/%h/%h expected 042 7f/19/24", bcd, hex2, hex1, hex0);
        else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        int t, t1, t2;
        logic [11:0] b1, b2;
        tick();
        in_data  = 8'd9;
        in_valid = 1'b1;
        tick();                 // accept edge of 9
        in_data  = 8'd42;       // held valid through busy
        t  = 0;
        t1 = -1;
        t2 = -1;
        b1 = '0;
        b2 = '0;
        while (t < 40 && t2 < 0) begin
            tick();
            t++;
            if (done) begin
                if (t1 < 0) begin
                    t1 = t;
                    b1 = bcd;
                end else begin
                    t2 = t;
                    b2 = bcd;
                end
            end
            if (t1 >= 0 && t == t1 + 1) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (t1 != 9 || b1 !== 12'h009) $display("FAIL busy_first: got t=%0d bcd=%h expected t=9 bcd=009", t1, b1);
        else pass_cnt++;
        total_cnt++;
        if (t2 < 0 || (t2 - t1) != 10 || b2 !== 12'h042)
            $display("FAIL busy_second: got gap=%0d bcd=%h expected gap=10 bcd=042", t2 - t1, b2);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat, bn, hc, dn; bit to;
        tick();
        in_data  = 8'd200;
        in_valid = 1'b1;
        tick();                 // accept
        in_valid = 1'b0;
        tick();                 // shift 1
        tick();                 // shift 2
        tick();                 // shift 3
        rst = 1'b1;
        tick();                 // 4th shift edge sees reset
        rst = 1'b0;
        total_cnt++;
        if ({in_ready, busy, done} !== 3'b100 || bcd !== 12'h000)
            $display("FAIL midreset_state: got rdy/busy/done=%b bcd=%h expected 100 000", {in_ready, busy, done}, bcd);
        else pass_cnt++;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dn++;
        end
        total_cnt++;
        if (dn != 0) $display("FAIL midreset_no_done: got %0d expected 0", dn);
        else pass_cnt++;
        convert(8'd200, lat, bn, hc, to);
        total_cnt++;
        if (to || {bcd, hex2, hex1, hex0} !== {12'h200, 7'h24, 7'h40, 7'h40})
            $display("FAIL midreset_200: got bcd=%h hex=%h/%h/%h expected 200 24/40/40", bcd, hex2, hex1, hex0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat, bn, hc, v;
        bit to;
        logic [11:0] eb;
        logic [20:0] eh;
        for (int n = 0; n < 24; n++) begin
            if (n == 0) v = 255;
            else if (n == 1) v = 0;
            else v = int'($urandom_range(255, 0));
            convert(8'(v), lat, bn, hc, to);
            eb = model_bcd(v);
            eh = model_hex(v);
            total_cnt++;
            if (to || bcd !== eb || {hex2, hex1, hex0} !== eh)
                $display("FAIL b2b_value v=%0d: got bcd=%h hex=%h expected bcd=%h hex=%h", v, bcd, {hex2, hex1, hex0}, eb, eh);
            else pass_cnt++;
            total_cnt++;
            if (hc != 0) $display("FAIL b2b_hold v=%0d: got %0d changes expected 0", v, hc);
            else pass_cnt++;
        end
    endtask

    initial begin
        seg_lo[0] = 7'h40; seg_lo[1] = 7'h79; seg_lo[2] = 7'h24; seg_lo[3] = 7'h30;
        seg_lo[4] = 7'h19; seg_lo[5] = 7'h12; seg_lo[6] = 7'h02; seg_lo[7] = 7'h78;
        seg_lo[8] = 7'h00; seg_lo[9] = 7'h10;
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        #2;
        test_reset();
        test_zero();
        test_max();
        test_blanking();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
